// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder cell, reused as the single bit-slice of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice processes one bit per clock, LSB first,
// with the carry held in a flop; sum/cout are presented with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] shift_a_r;
  logic [WIDTH-1:0] shift_b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] sum_next_s;

  fulladder u_fa (
    .a    (shift_a_r[0]),
    .b    (shift_b_r[0]),
    .c    (carry_r),
    .s    (fa_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the MSB; a 1-bit adder simply replaces its only bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next_s = fa_s;
    end else begin : g_wn
      assign sum_next_s = {fa_s, sum_r[WIDTH-1:1]};
    end
  endgenerate

  // FSM, operand shifters, carry flop, bit counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_a_r <= '0;
      shift_b_r <= '0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      count_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            shift_a_r <= a;
            shift_b_r <= b;
            carry_r   <= cin;
            count_r   <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here: a running addition is never reloaded
          shift_a_r <= shift_a_r >> 1'b1;
          shift_b_r <= shift_b_r >> 1'b1;
          sum_r     <= sum_next_s;
          carry_r   <= fa_cout_s;
          count_r   <= count_r + CW'(1);
          if (count_r == LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total;
  int bad;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive start for one edge, then scramble the operands to prove they were latched.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc;
  endtask

  // Position p = edges since the start edge; done is expected when p == WIDTH.
  task automatic wait_done(input int p0, output int p, output int busy_cnt);
    p = p0;
    busy_cnt = 0;
    while (!done && p < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      p++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec);
    int p, bc;
    launch(ta, tb, tc);
    wait_done(0, p, bc);
    chk({tag, "_lat"}, p, 32'd8);
    chk({tag, "_busy"}, bc, 32'd8);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {23'd0, cout, sum}, {23'd0, ec, es});
  endtask

  initial begin
    int p, bc, npulse;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {21'd0, busy, done, cout, sum}, 32'd0);
    rst = 1'b0;

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Second start during RUN must be ignored.
    launch(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, p, bc);
    chk("ign_lat", p, 32'd8);
    chk("ign_sum", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h10});
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("ign_extra_done", npulse, 32'd0);

    // Back-to-back: start held through the done cycle.
    launch(8'h01, 8'h02, 1'b0);
    wait_done(0, p, bc);
    chk("b2b_first", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h03});
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {30'd0, busy, done}, 32'd2);
    wait_done(0, p, bc);
    chk("b2b_gap", p + 1, 32'd9);
    chk("b2b_sum", {23'd0, cout, sum}, {23'd0, 1'b1, 8'h01});

    // Reset mid-RUN discards the addition.
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", {21'd0, busy, done, cout, sum}, 32'd0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) npulse++;
    end
    chk("midrst_quiet", npulse, 32'd0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
